// File: rtl/chacha_pkg.sv
// ChaCha stream host shared package: block/load
// sizes and the host sequencer state encoding.
package chacha_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int LOAD_BYTES  = 48;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GUARD,
    WAIT,
    STREAM
  } host_state_e;

endpackage

// File: rtl/chacha_stream_host_if.sv
// Host-side byte streams of the ChaCha stream host:
// config in, data in, XORed data out.
interface chacha_stream_host_if;

  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

endinterface

// File: rtl/chacha_xor_stage.sv
// Output register: XORs data with keystream and
// holds the result until the consumer takes it.
module chacha_xor_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fire_i,
  input  logic [7:0] in_data_i,
  input  logic [7:0] ks_byte_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       slot_free_o
);

  logic       valid_q;
  logic [7:0] data_q;

  // Load on fire (even while draining); else drop
  // valid once the consumer has taken the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else if (fire_i) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i ^ ks_byte_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign slot_free_o = !valid_q || out_ready_i;

endmodule

// File: rtl/chacha_stream_host.sv
// ChaCha stream host: loads the core, then XORs its
// keystream onto the data stream. CHACHA_HOST_BLKCNT_EN adds a block counter.
module chacha_stream_host
  import chacha_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  chacha_stream_host_if.slave bus,
  output logic       blk_write,
  output logic [7:0] blk_data_in,
  output logic       blk_read,
  input  logic [7:0] blk_data_out,
  input  logic       blk_ready
`ifdef CHACHA_HOST_BLKCNT_EN
  ,
  output logic [15:0] blk_count,
  output logic        blk_count_sat
`endif
);

  localparam logic [5:0] LOAD_LAST =
    6'(LOAD_BYTES - 1);
  localparam logic [5:0] BLK_LAST =
    6'(BLOCK_BYTES - 1);

  host_state_e state_q;
  logic [5:0]  load_cnt_q;
  logic [5:0]  byte_cnt_q;
  logic        cfg_ready_q;

  logic       wr;
  logic       rd;
  logic       in_ready;
  logic       slot_free;
  logic       out_valid;
  logic [7:0] out_data;

  assign wr = bus.cfg_valid && cfg_ready_q;

  assign in_ready = (state_q == STREAM)
                    && blk_ready && slot_free;

  assign rd = bus.in_valid && in_ready;

  assign blk_write   = wr;
  assign blk_data_in = wr ? bus.cfg_data : 8'h00;
  assign blk_read    = rd;

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

  // Sequencer: load config, guard one cycle for
  // the core's lagging ready, wait, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_cnt_q  <= 6'd0;
      byte_cnt_q  <= 6'd0;
      cfg_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cfg_ready_q <= 1'b1;
          if (wr) begin
            load_cnt_q <= 6'd1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (wr) begin
            load_cnt_q <= load_cnt_q + 6'd1;
            if (load_cnt_q == LOAD_LAST) begin
              cfg_ready_q <= 1'b0;
              state_q     <= GUARD;
            end
          end
        end
        GUARD: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (blk_ready) begin
            byte_cnt_q <= 6'd0;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (rd) begin
            byte_cnt_q <= byte_cnt_q + 6'd1;
            if (byte_cnt_q == BLK_LAST) begin
              state_q <= GUARD;
            end
          end
        end
        default: begin
          cfg_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  chacha_xor_stage u_xor (
    .clk         (clk),
    .rst_n       (rst_n),
    .fire_i      (rd),
    .in_data_i   (bus.in_data),
    .ks_byte_i   (blk_data_out),
    .out_ready_i (bus.out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .slot_free_o (slot_free)
  );

`ifdef CHACHA_HOST_BLKCNT_EN
  logic [15:0] blk_cnt_q;
  logic        last_rd;

  assign last_rd = rd && (byte_cnt_q == BLK_LAST);

  // Count fully consumed blocks, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= 16'h0000;
    end else if (last_rd && !(&blk_cnt_q)) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_count     = blk_cnt_q;
  assign blk_count_sat = &blk_cnt_q;
`endif

endmodule
